// File: rtl/pci_sram_pkg.sv
// Shared types and helpers for the PCI target SRAM.
// State encoding, byte-lane width and byte-enable expansion.
package pci_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_e;

  function automatic int DW_BYTES(input int dw);
    return dw / 8;
  endfunction

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++)
      m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/pci_target_sram_if.sv
// Bus bundle between the PCI target front end and the SRAM target.
// master drives phases and data; slave claims, readies and returns data.
interface pci_target_sram_if #(
  parameter int DATA_W = 32
);

  logic                  start;
  logic [31:0]           addr_in;
  logic                  we;
  logic [29:0]           add_start;
  logic [29:0]           add_end;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic                  valid;
  logic                  done;
  logic [DATA_W-1:0]     data_out;
  logic                  data_out_vld;
  logic                  devsel_n;
  logic                  ready;
  logic                  last_add;
  logic                  abort;

  modport master (
    output start, addr_in, we,
    output add_start, add_end,
    output data_in, be, valid, done,
    input  data_out, data_out_vld,
    input  devsel_n, ready,
    input  last_add, abort
  );

  modport slave (
    input  start, addr_in, we,
    input  add_start, add_end,
    input  data_in, be, valid, done,
    output data_out, data_out_vld,
    output devsel_n, ready,
    output last_add, abort
  );

endinterface

// File: rtl/pci_sram_array.sv
// Single-port SRAM with per-byte write enables
// and a registered read port that holds its last value.
module pci_sram_array
  import pci_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          we,
  input  logic [DW_BYTES(DATA_W)-1:0]   wbe,
  input  logic [AW-1:0]                 addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int BW = DW_BYTES(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BW; b++) begin
        if (wbe[b])
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we)
      rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata_q <= '0;
    else
      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pci_target_sram.sv
// PCI target memory: window decode, burst FSM and address pointer.
// Define PCI_SRAM_BYTE_MERGE_EN to keep disabled bytes instead of zeroing.
module pci_target_sram
  import pci_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  pci_target_sram_if.slave   bus
);

  localparam int BW   = DW_BYTES(DATA_W);
  localparam int SH   = (DATA_W == 64) ? 1 : 0;
  localparam int CAP  = DEPTH * (DATA_W / 32);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state_q, state_d;
  logic [30:0]   ptr_q, ptr_d;
  logic          we_q, we_d;
  logic          vld_q, vld_d;

  logic [29:0]   a_base;
  logic          hit;
  logic [31:0]   off;
  logic [31:0]   idx_full;
  logic          in_rng;
  logic          active;
  logic          beat;
  logic [BW-1:0]     wbe;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  // Wide builds address even dword pairs, so bit 2 is dropped.
  assign a_base = bus.addr_in[31:2] & ~30'(SH);

  assign hit = (a_base >= bus.add_start)
            && (a_base <= bus.add_end)
            && (({2'b0, a_base} - {2'b0, bus.add_start})
                < 32'(CAP));

  assign off      = {1'b0, ptr_q} - {2'b0, bus.add_start};
  assign idx_full = off >> SH;

  assign in_rng = (ptr_q <= {1'b0, bus.add_end})
               && (off < 32'(CAP));

  assign active = (state_q == ACTIVE);
  assign beat   = active && in_rng && bus.valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    vld_d   = beat && !we_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && hit) begin
          state_d = ACTIVE;
          ptr_d   = {1'b0, a_base};
          we_d    = bus.we;
        end
      end
      ACTIVE: begin
        if (bus.valid && !in_rng) begin
          state_d = ABORT;
        end else begin
          if (beat)
            ptr_d = ptr_q + 31'(SH + 1);
          if (bus.done)
            state_d = IDLE;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      vld_q   <= vld_d;
    end
  end

`ifdef PCI_SRAM_BYTE_MERGE_EN
  assign wbe   = bus.be;
  assign wdata = bus.data_in;
`else
  // Legacy masking: the whole word is written, disabled lanes as zero.
  logic [63:0] mask64;
  logic        unused_mask;
  assign mask64      = be_mask(8'(bus.be));
  assign wbe         = '1;
  assign wdata       = bus.data_in & mask64[DATA_W-1:0];
  assign unused_mask = ^mask64;
`endif

  pci_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (beat),
    .we     (we_q),
    .wbe    (wbe),
    .addr   (idx_full[AW-1:0]),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  assign bus.data_out     = rdata;
  assign bus.data_out_vld = vld_q;
  assign bus.devsel_n     = !active;
  assign bus.ready        = active && in_rng;
  assign bus.abort        = (state_q == ABORT);
  assign bus.last_add     = active
    && ((ptr_q & ~31'(SH)) == ({1'b0, bus.add_end} & ~31'(SH)));

  logic unused_ok;
  assign unused_ok = ^{bus.addr_in[1:0], idx_full};

endmodule
